// File: rtl/muxn_reg.sv
// muxn_reg: registered N-to-1 channel mux with valid/ready handshakes, selecting by
// explicit index or round-robin. Optional X-check on sel: define MUXN_XCHECK_EN.
module muxn_reg #(
  parameter int N    = 4,
  parameter int W    = 1,
  parameter int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   grant,
  output logic              err
);

  // Handshake semantics: a word moves on any edge where valid and ready are both
  // high; in_ready never waits on in_valid except for the round-robin choice.

  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] grant_q, grant_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic            load;
  logic [SELW-1:0] chosen;
  logic            chosen_ok;
  logic            sel_x;
  logic [W-1:0]    chosen_data;
  logic            capture;

  function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return SELW'(s);
  endfunction

  assign load = !out_valid_q || out_ready;

`ifdef MUXN_XCHECK_EN
  assign sel_x = !mode && load && $isunknown(sel);
`else
  assign sel_x = 1'b0;
`endif

  always_comb begin
    chosen    = '0;
    chosen_ok = 1'b0;
    if (!mode) begin
      chosen    = sel;
      chosen_ok = (32'(sel) < 32'(N));
    end else begin
      // Walk the scan order backwards so the earliest valid channel wins.
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[rr_idx(ptr_q, k)]) begin
          chosen    = rr_idx(ptr_q, k);
          chosen_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready    = '0;
    chosen_data = '0;
    for (int i = 0; i < N; i++) begin
      if (chosen == SELW'(i)) begin
        chosen_data = in_data[i*W +: W];
        if (rst_n && load && chosen_ok && !sel_x) in_ready[i] = 1'b1;
      end
    end
  end

  assign capture = |(in_ready & in_valid);

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    if (sel_x) begin
      out_data_d  = {W{1'bx}};
      out_valid_d = 1'b1;
    end else if (capture) begin
      out_data_d  = chosen_data;
      out_valid_d = 1'b1;
      grant_d     = chosen;
      if (mode) ptr_d = (chosen == SELW'(N - 1)) ? '0 : chosen + SELW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef MUXN_XCHECK_EN
  logic err_q, err_d;

  // Sticky until reset so a single bad select is never lost.
  assign err_d = err_q || sel_x;

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_muxn_reg.sv
// Directed and randomized bench for muxn_reg (N=6, W=8) with an expected-word queue.
module tb_muxn_reg;

  localparam int N    = 6;
  localparam int W    = 8;
  localparam int SELW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mode = 1'b0;
  logic [SELW-1:0] sel = '0;
  logic [N*W-1:0]  in_data = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [SELW-1:0] grant;
  logic            err;

  logic [SELW+W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  muxn_reg #(.N(N), .W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    return {16'($urandom), $urandom};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mode = 1'b1; in_valid = '1; out_ready = 1'b0; in_data = rnd_data();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = '0;
    exp_q.delete();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_err", 32'(err), 32'h0);
  endtask

  // One cycle: drive, check the held word against the queue head, check in_ready,
  // and queue the word expected to be captured at the coming edge.
  task automatic step(input logic md, input logic [SELW-1:0] sl, input logic [N-1:0] vld,
                      input logic ordy, input int exp_ch, input logic [N*W-1:0] dat);
    logic [N-1:0] exp_rdy;
    logic         has;
    logic         ld;
    @(negedge clk);
    rst_n = 1'b1; mode = md; sel = sl; in_valid = vld; out_ready = ordy; in_data = dat;
    #1;
    has = (exp_q.size() > 0);
    ld  = !has || ordy;
    check("out_valid", 32'(out_valid), 32'(has));
    if (has) begin
      check("out_data", 32'(out_data), 32'(exp_q[0][W-1:0]));
      check("grant", 32'(grant), 32'(exp_q[0][SELW+W-1:W]));
      if (ordy) void'(exp_q.pop_front());
    end
    exp_rdy = '0;
    if (ld && exp_ch >= 0) exp_rdy[exp_ch] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("err", 32'(err), 32'h0);
    if (exp_ch >= 0 && exp_rdy[exp_ch] && vld[exp_ch])
      exp_q.push_back({SELW'(exp_ch), dat[exp_ch*W +: W]});
  endtask

  task automatic drain();
    step(1'b0, 3'd0, '0, 1'b1, 0, rnd_data());
  endtask

  initial begin
    logic [N*W-1:0] d;
    logic [SELW-1:0] s;
    do_reset();

    // Fixed select of channel 2 carrying 0xA5.
    d = rnd_data(); d[2*W +: W] = 8'hA5;
    step(1'b0, 3'd2, 6'b000100, 1'b1, 2, d);
    // Backpressure: held word stays put, no channel is ready.
    for (int i = 0; i < 5; i++) step(1'b0, 3'd1, 6'b111111, 1'b0, 1, rnd_data());
    // Release: drain and accept channel 1 in the same cycle.
    step(1'b0, 3'd1, 6'b111111, 1'b1, 1, rnd_data());
    drain();
    drain();

    // Top channel, then out-of-range selects.
    step(1'b0, 3'd5, 6'b100000, 1'b1, 5, rnd_data());
    step(1'b0, 3'd7, 6'b111111, 1'b1, -1, rnd_data());
    step(1'b0, 3'd6, 6'b111111, 1'b1, -1, rnd_data());

    // Round-robin, channels 0..3 valid: 0,1,2,3,0.
    step(1'b1, 3'd0, 6'b001111, 1'b1, 0, rnd_data());
    step(1'b1, 3'd0, 6'b001111, 1'b1, 1, rnd_data());
    step(1'b1, 3'd0, 6'b001111, 1'b1, 2, rnd_data());
    step(1'b1, 3'd0, 6'b001111, 1'b1, 3, rnd_data());
    step(1'b1, 3'd0, 6'b001111, 1'b1, 0, rnd_data());
    // Channels 1 and 3 only: 1,3,1,3.
    step(1'b1, 3'd0, 6'b001010, 1'b1, 1, rnd_data());
    step(1'b1, 3'd0, 6'b001010, 1'b1, 3, rnd_data());
    step(1'b1, 3'd0, 6'b001010, 1'b1, 1, rnd_data());
    step(1'b1, 3'd0, 6'b001010, 1'b1, 3, rnd_data());
    // Pointer survives a detour through fixed mode (next scan starts at 4).
    step(1'b0, 3'd0, 6'b000000, 1'b1, 0, rnd_data());
    step(1'b1, 3'd0, 6'b111111, 1'b1, 4, rnd_data());
    step(1'b1, 3'd0, 6'b111111, 1'b1, 5, rnd_data());
    step(1'b1, 3'd0, 6'b111111, 1'b1, 0, rnd_data());
    // Backpressure in round-robin leaves the pointer alone.
    step(1'b1, 3'd0, 6'b111111, 1'b0, 1, rnd_data());
    step(1'b1, 3'd0, 6'b111111, 1'b0, 1, rnd_data());
    step(1'b1, 3'd0, 6'b111111, 1'b1, 1, rnd_data());
    // Nothing valid: no channel ready.
    step(1'b1, 3'd0, 6'b000000, 1'b1, -1, rnd_data());
    step(1'b1, 3'd0, 6'b000000, 1'b1, -1, rnd_data());

    // Reset mid-transfer with pointer at 2.
    step(1'b1, 3'd0, 6'b000010, 1'b1, 1, rnd_data());
    step(1'b1, 3'd0, 6'b000000, 1'b0, -1, rnd_data());
    do_reset();
    step(1'b1, 3'd0, 6'b111111, 1'b1, 0, rnd_data());
    drain();

    // Random fixed-mode traffic with random backpressure.
    for (int i = 0; i < 40; i++) begin
      s = 3'($urandom_range(7, 0));
      step(1'b0, s, 6'($urandom), 1'($urandom_range(1, 0)), (s < 3'd6) ? int'(s) : -1, rnd_data());
    end
    drain();
    drain();

`ifdef MUXN_XCHECK_EN
    @(negedge clk);
    mode = 1'b0; sel = 3'bx01; in_valid = '1; out_ready = 1'b1; in_data = rnd_data();
    #1;
    check("x_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    sel = 3'd0; in_valid = '0; out_ready = 1'b0;
    #1;
    check("x_out_valid", 32'(out_valid), 32'h1);
    check("x_out_data", {24'h0, out_data}, {24'h0, 8'hxx});
    check("x_err", 32'(err), 32'h1);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    @(negedge clk);
    #1;
    check("x_err_hold", 32'(err), 32'h1);
    check("x_drained", 32'(out_valid), 32'h0);
    do_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muxn_reg.md
# muxn_reg

Parametrised, registered N-to-1 channel multiplexer with valid/ready handshakes; next generation of the team's 4-to-1 single-bit mux. Selects one of N W-bit input channels, either by explicit select or by round-robin arbitration among valid channels, and holds the result in an output register. Sits between multi-source producers and a single consumer in datapath test structures. X-propagation checking is part of the equivalence benches.

## Interface
- `N`, default 4: number of input channels, N ≥ 2.
- `W`, default 1: data width per channel, W ≥ 1.
- `SELW`, default $clog2(N): select/grant width, derived; do not override.

- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `mode`, input, 1: 0 = fixed select via `sel`; 1 = round-robin.
- `sel`, input, SELW: channel index in fixed mode; ignored in round-robin.
- `in_data`, input, N*W: channel i occupies bits [i*W +: W].
- `in_valid`, input, N: per-channel valid.
- `in_ready`, output, N: per-channel ready, combinational.
- `out_data`, output, W: registered selected data.
- `out_valid`, output, 1: output register holds data.
- `out_ready`, input, 1: consumer accepts `out_data` this cycle.
- `grant`, output, SELW: registered index of the channel held in `out_data`.
- `err`, output, 1: sticky select-error flag; see Configuration.

## Operation
- `load = !out_valid || out_ready`: output register can accept this cycle.
- `chosen` channel:
  - Fixed mode: `chosen = sel`. When `sel ≥ N`, no channel is chosen.
  - Round-robin mode: first i with `in_valid[i]`, scanning ptr, ptr+1, … mod N. When no channel is valid, no channel is chosen.
- `in_ready[i] = load && (i == chosen)`. All other bits are 0. Exactly zero or one bit is set.
- Capture when `in_ready[chosen] && in_valid[chosen]`:
  - `out_data <= in_data[chosen]`
  - `grant <= chosen`
  - `out_valid <= 1`
- When `out_ready && out_valid` and nothing is captured: `out_valid <= 0`. `out_data` and `grant` hold their values.
- While `out_valid && !out_ready`: `out_data`, `grant` and `out_valid` are stable, and all `in_ready` bits are 0.
- Round-robin pointer `ptr` (SELW bits):
  - Updates only on capture in round-robin mode: `ptr <= (chosen == N-1) ? 0 : chosen+1`.
  - Holds in fixed mode.
- `mode` changes take effect in the same cycle. `ptr` is retained across mode changes.
- Reset (`rst_n` = 0 at an edge): `out_valid` = 0, `out_data` = 0, `grant` = 0, `ptr` = 0, `err` = 0. While `rst_n` is low, `in_ready` is forced to 0. Reset mid-transfer discards the held word.

## Timing
- Latency: 1 cycle from input handshake to `out_valid`.
- Throughput: one word per cycle when `out_ready` is held high.
- Simultaneous drain and capture in the same cycle: the new word replaces the old one, and `out_valid` stays 1.
- Only `in_ready` is combinational. It depends on `mode`, `sel`, `in_valid` (round-robin only), `out_valid` and `out_ready`. There is no path from `in_valid` to `in_ready` in fixed mode.

## Configuration
- `MUXN_XCHECK_EN` defined (simulation only):
  - Trigger: in fixed mode, at an edge where `load` = 1, any bit of `sel` is X/Z.
  - Response: no capture, all `in_ready` = 0, `out_data <= {W{1'bx}}` with `out_valid <= 1`, and `err <= 1`.
  - `err` clears only on reset.
- Undefined: no X/Z check; `err` is tied to 0, and X on `sel` behaves as the native case/compare semantics of the RTL.

## Test plan
- Fixed mode, N=4, W=8, `sel` = 2, `in_data[2]` = 0xA5 valid, `out_ready` = 1 → `in_ready` = 4'b0100; next cycle `out_data` = 0xA5, `grant` = 2, `out_valid` = 1.
- Backpressure: `out_ready` = 0 with `out_valid` = 1 for 5 cycles → `in_ready` = 0, `out_data` stable. Raise `out_ready` → drains, then accepts in the same cycle.
- Round-robin: all 4 channels valid continuously, `out_ready` = 1 → `grant` sequence 0,1,2,3,0. With only channels 1 and 3 valid → 1,3,1,3.
- `sel` = 5 with N=6 valid accepted; `sel` = 7 with N=6 → `in_ready` = 0, `out_valid` falls after drain.
- Reset pulse while `out_valid` = 1 and round-robin `ptr` = 2 → next cycle `out_valid` = 0, `grant` = 0, and the next round-robin grant starts scan at 0.
- With `MUXN_XCHECK_EN` defined: `sel` = 2'bx1 → `out_data` all X, `err` = 1, and `err` holds until `rst_n` is asserted.
